// File: rtl/digits_to_bin.sv
// Sequential radix-to-binary recombiner: rebuilds a binary value from DIGITS
// base-BASE digits (most significant first) by Horner evaluation, one digit per clock.
module digits_to_bin #(
  parameter int BASE   = 10,
  parameter int DIGITS = 3,
  parameter int W_DIG  = 4,
  parameter int W_OUT  = 9
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [DIGITS*W_DIG-1:0] digits,
  output logic                    busy,
  output logic                    done,
  output logic [W_OUT-1:0]        value,
  output logic                    err_digit,
  output logic                    overflow
);

  // Wide enough that acc*BASE + digit never loses a bit.
  localparam int WX   = W_OUT + W_DIG + 1;
  localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDXW-1:0]  IDX_TOP  = IDXW'(DIGITS - 1);
  localparam logic [IDXW-1:0]  IDX_ZERO = IDXW'(0);
  localparam logic [IDXW-1:0]  IDX_ONE  = IDXW'(1);
  localparam logic [WX-1:0]    BASE_X   = WX'(BASE);
  localparam logic [W_DIG:0]   BASE_D   = (W_DIG + 1)'(BASE);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                    r_state;
  logic [DIGITS*W_DIG-1:0]   r_shadow;
  logic [W_OUT-1:0]          r_acc;
  logic [IDXW-1:0]           r_idx;
  logic                      r_err;
  logic                      r_ovf;

  state_t                    w_state_nxt;
  logic [DIGITS*W_DIG-1:0]   w_shadow_nxt;
  logic [W_OUT-1:0]          w_acc_nxt;
  logic [IDXW-1:0]           w_idx_nxt;
  logic                      w_err_nxt;
  logic                      w_ovf_nxt;
  logic                      w_done_nxt;
  logic [W_OUT-1:0]          w_value_nxt;
  logic                      w_err_digit_nxt;
  logic                      w_overflow_nxt;
  logic                      w_busy_nxt;

  logic [W_DIG-1:0]          w_dig;
  logic                      w_bad;
  logic [WX-1:0]             w_sum;
  logic                      w_wrap;
  logic                      w_err_acc;
  logic                      w_ovf_acc;

  // One Horner step on the currently selected digit.
  always_comb begin
    w_dig     = r_shadow[r_idx*W_DIG +: W_DIG];
    w_bad     = ({1'b0, w_dig} >= BASE_D);
    w_sum     = (WX'(r_acc) * BASE_X) + WX'(w_dig);
    w_wrap    = |w_sum[WX-1:W_OUT];
    w_err_acc = r_err | w_bad;
    w_ovf_acc = r_ovf | w_wrap;
  end

  // Next-state and next-output decode.
  always_comb begin
    w_state_nxt     = r_state;
    w_shadow_nxt    = r_shadow;
    w_acc_nxt       = r_acc;
    w_idx_nxt       = r_idx;
    w_err_nxt       = r_err;
    w_ovf_nxt       = r_ovf;
    w_done_nxt      = 1'b0;
    w_value_nxt     = value;
    w_err_digit_nxt = err_digit;
    w_overflow_nxt  = overflow;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt     = S_CONV;
          w_shadow_nxt    = digits;
          w_acc_nxt       = {W_OUT{1'b0}};
          w_idx_nxt       = IDX_TOP;
          w_err_nxt       = 1'b0;
          w_ovf_nxt       = 1'b0;
          w_err_digit_nxt = 1'b0;
          w_overflow_nxt  = 1'b0;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_CONV: begin
        // Accumulator keeps running modulo 2^W_OUT once it has wrapped.
        w_acc_nxt = w_sum[W_OUT-1:0];
        w_err_nxt = w_err_acc;
        w_ovf_nxt = w_ovf_acc;
        if (r_idx == IDX_ZERO) begin
          w_value_nxt     = w_err_acc ? {W_OUT{1'b0}} : w_sum[W_OUT-1:0];
          w_err_digit_nxt = w_err_acc;
          w_overflow_nxt  = w_ovf_acc;
          w_done_nxt      = 1'b1;
          w_state_nxt     = S_DONE;
        end else begin
          w_idx_nxt   = r_idx - IDX_ONE;
          w_state_nxt = S_CONV;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_shadow  <= {(DIGITS*W_DIG){1'b0}};
      r_acc     <= {W_OUT{1'b0}};
      r_idx     <= IDX_ZERO;
      r_err     <= 1'b0;
      r_ovf     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      value     <= {W_OUT{1'b0}};
      err_digit <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_shadow  <= w_shadow_nxt;
      r_acc     <= w_acc_nxt;
      r_idx     <= w_idx_nxt;
      r_err     <= w_err_nxt;
      r_ovf     <= w_ovf_nxt;
      busy      <= w_busy_nxt;
      done      <= w_done_nxt;
      value     <= w_value_nxt;
      err_digit <= w_err_digit_nxt;
      overflow  <= w_overflow_nxt;
    end
  end

endmodule

// File: tb/tb_digits_to_bin.sv
// Scoreboard bench for digits_to_bin: decimal default instance plus a hex
// (BASE=16, W_OUT=12) instance; expectations come from a positional-sum model.
module tb_digits_to_bin;

  logic        clk = 1'b0;
  logic        reset, start, start_h;
  logic [11:0] digits, digits_h;
  logic        busy, done, err_digit, overflow;
  logic [8:0]  value;
  logic        busy_h, done_h, err_h, ovf_h;
  logic [11:0] value_h;

  typedef struct {
    int value;
    bit err;
    bit ovf;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   last_value = 0;

  always #5 clk = ~clk;

  digits_to_bin u_dut (
    .clk(clk), .reset(reset), .start(start), .digits(digits),
    .busy(busy), .done(done), .value(value),
    .err_digit(err_digit), .overflow(overflow)
  );

  digits_to_bin #(.BASE(16), .DIGITS(3), .W_DIG(4), .W_OUT(12)) u_hex (
    .clk(clk), .reset(reset), .start(start_h), .digits(digits_h),
    .busy(busy_h), .done(done_h), .value(value_h),
    .err_digit(err_h), .overflow(ovf_h)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Weighted sum of digits; error if any digit is out of range.
  function automatic exp_t model(input logic [11:0] d, input int base, input int w_out);
    exp_t   r;
    longint t  = 0;
    longint pw = 1;
    r.err = 1'b0;
    for (int i = 0; i < 3; i++) begin
      logic [3:0] dg;
      dg = d[i*4 +: 4];
      if (int'(dg) >= base) r.err = 1'b1;
      t  += longint'(dg) * pw;
      pw *= base;
    end
    r.ovf   = (t >= (longint'(1) << w_out));
    r.value = r.err ? 0 : int'(t % (longint'(1) << w_out));
    return r;
  endfunction

  // One conversion from idle; returns in the first idle cycle afterwards.
  task automatic run_conv(input logic [11:0] d, input string nm);
    exp_t e;
    digits = d;
    start  = 1'b1;
    sb.push_back(model(d, 10, 9));
    step();
    start = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      checks++;
      if (busy !== (c <= 4)) begin
        failures++;
        $display("FAIL %s busy c%0d: got %b expected %b", nm, c, busy, (c <= 4));
      end
      checks++;
      if (done !== (c == 4)) begin
        failures++;
        $display("FAIL %s done c%0d: got %b expected %b", nm, c, done, (c == 4));
      end
      if (c == 1) begin
        checks++;
        if ({err_digit, overflow} !== 2'b00) begin
          failures++;
          $display("FAIL %s flags_clear: got %b%b expected 00", nm, err_digit, overflow);
        end
      end
      if (c < 4) begin
        checks++;
        if (value !== 9'(last_value)) begin
          failures++;
          $display("FAIL %s value_held c%0d: got %0d expected %0d", nm, c, value, last_value);
        end
      end
      if (done === 1'b1 && sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (value !== 9'(e.value) || err_digit !== e.err || overflow !== e.ovf) begin
          failures++;
          $display("FAIL %s result: got v=%0d e=%b o=%b expected v=%0d e=%b o=%b",
                   nm, value, err_digit, overflow, e.value, e.err, e.ovf);
        end
        last_value = e.value;
      end
      if (c < 5) step();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; digits = 12'h375;
    start_h = 1'b0; digits_h = 12'h000;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if ({busy, done, value, err_digit, overflow} !== 13'd0) begin
        failures++;
        $display("FAIL reset_outputs c%0d: got b=%b d=%b v=%0d e=%b o=%b expected all 0",
                 c, busy, done, value, err_digit, overflow);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    run_conv(12'h375, "basic_375");
  endtask

  task automatic test_overflow();
    run_conv(12'h511, "ovf_511");
    run_conv(12'h512, "ovf_512");
    run_conv(12'h999, "ovf_999");
  endtask

  task automatic test_invalid();
    run_conv(12'h1A2, "invalid_1A2");
    checks++;
    if (err_digit !== 1'b1) begin
      failures++;
      $display("FAIL err_held: got %b expected 1", err_digit);
    end
    run_conv(12'h042, "after_invalid");
  endtask

  task automatic test_ignore_start();
    exp_t e;
    int   n_done = 0;
    digits = 12'h123;
    start  = 1'b1;
    sb.push_back(model(12'h123, 10, 9));
    step();
    for (int c = 1; c <= 10; c++) begin
      start = (c == 2 || c == 4);
      if (c == 1) digits = 12'h999;
      checks++;
      if (busy !== (c <= 4)) begin
        failures++;
        $display("FAIL ignore busy c%0d: got %b expected %b", c, busy, (c <= 4));
      end
      if (done === 1'b1) begin
        n_done++;
        if (sb.size() > 0) begin
          e = sb.pop_front();
          checks++;
          if (value !== 9'(e.value)) begin
            failures++;
            $display("FAIL ignore value: got %0d expected %0d", value, e.value);
          end
          last_value = e.value;
        end
      end
      step();
    end
    start = 1'b0;
    checks++;
    if (n_done != 1) begin
      failures++;
      $display("FAIL ignore done_count: got %0d expected 1", n_done);
    end
  endtask

  task automatic test_reset_mid();
    digits = 12'h375;
    start  = 1'b1;
    step();
    start = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if (busy !== 1'b0 || value !== 9'd0) begin
      failures++;
      $display("FAIL reset_mid c3: got busy=%b value=%0d expected busy=0 value=0", busy, value);
    end
    for (int c = 0; c < 8; c++) begin
      checks++;
      if (done !== 1'b0 || value !== 9'd0) begin
        failures++;
        $display("FAIL reset_mid no_done: got done=%b value=%0d expected 0 0", done, value);
      end
      step();
    end
    last_value = 0;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    digits = 12'h042;
    start  = 1'b1;
    for (int k = 0; k < 3; k++) sb.push_back(model(12'h042, 10, 9));
    for (int c = 0; c < 15; c++) begin
      checks++;
      if (busy !== ((c % 5) != 0)) begin
        failures++;
        $display("FAIL b2b busy c%0d: got %b expected %b", c, busy, ((c % 5) != 0));
      end
      checks++;
      if (done !== ((c % 5) == 4)) begin
        failures++;
        $display("FAIL b2b done c%0d: got %b expected %b", c, done, ((c % 5) == 4));
      end
      if (done === 1'b1 && sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (value !== 9'(e.value)) begin
          failures++;
          $display("FAIL b2b value c%0d: got %0d expected %0d", c, value, e.value);
        end
        last_value = e.value;
      end
      step();
    end
    start = 1'b0;
    step();
  endtask

  task automatic test_base16();
    exp_t e;
    int   seen = 0;
    e = model(12'hABC, 16, 12);
    digits_h = 12'hABC;
    start_h  = 1'b1;
    step();
    start_h = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      checks++;
      if (done_h !== (c == 4)) begin
        failures++;
        $display("FAIL hex done c%0d: got %b expected %b", c, done_h, (c == 4));
      end
      if (done_h === 1'b1) begin
        seen++;
        checks++;
        if (value_h !== 12'(e.value) || err_h !== e.err || ovf_h !== e.ovf) begin
          failures++;
          $display("FAIL hex result: got v=%0d e=%b o=%b expected v=%0d e=%b o=%b",
                   value_h, err_h, ovf_h, e.value, e.err, e.ovf);
        end
      end
      step();
    end
    checks++;
    if (seen != 1) begin
      failures++;
      $display("FAIL hex done_count: got %0d expected 1", seen);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_invalid();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    test_base16();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/digits_to_bin.md
Name: digits_to_bin

Overview:
- Sequential radix-to-binary recombiner; the inverse of the team's combinational digit splitter.
- Takes DIGITS base-BASE digits, most significant first, and rebuilds the binary value by Horner evaluation (acc = acc*BASE + digit), one digit per clock.
- Sits between the MasterMind digit-entry/guess registers and binary compare/score logic.
- Start/busy/done handshake; flags invalid digits and result overflow.

Parameters:
- BASE, 10, radix of input digits (2..16).
- DIGITS, 3, number of input digits (1..8).
- W_DIG, 4, bit width of one digit; must satisfy 2^W_DIG >= BASE.
- W_OUT, 9, width of binary result.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request conversion; sampled only while busy=0.
- digits  input  DIGITS*W_DIG  packed digits; digit i at [i*W_DIG +: W_DIG], i=0 least significant; captured on accepted start.
- busy  output  1  high from cycle after accepted start through the done cycle inclusive.
- done  output  1  one-cycle pulse; value and flags valid.
- value  output  W_OUT  converted result; held until next done.
- err_digit  output  1  some captured digit >= BASE; valid with done, held until next accepted start.
- overflow  output  1  true result >= 2^W_OUT; valid with done, held until next accepted start.

Behaviour:
- Reset values:
  - all outputs 0;
  - state IDLE;
  - internal accumulator, index and sticky flags 0.
- Reset has priority over everything and may arrive in any state.
  - After a reset mid-conversion: busy=0 in the next cycle, no done pulse, value=0.
- States: IDLE, CONV, DONE. busy = (state != IDLE), registered.
- IDLE:
  - start=1 accepts a conversion: capture digits into a shadow register, acc=0, idx=DIGITS-1.
  - Clear err_digit and overflow.
  - Go to CONV.
  - Later changes on digits are ignored.
- CONV, one digit per cycle, idx DIGITS-1 down to 0:
  - next = acc*BASE + d[idx], computed at width W_OUT+W_DIG+1 so no intermediate is lost.
  - If d[idx] >= BASE, set sticky err.
  - If next >= 2^W_OUT, set sticky ovf.
  - acc <= next[W_OUT-1:0]; arithmetic continues modulo 2^W_OUT after overflow.
  - On idx=0, at that edge:
    - value <= err ? 0 : final acc;
    - err_digit <= err; overflow <= ovf;
    - done <= 1; go to DONE.
- DONE: done <= 0, go to IDLE. start is ignored in DONE.
- Latency, with start accepted in cycle 0:
  - busy=1 in cycles 1..DIGITS+1;
  - done=1 only in cycle DIGITS+1;
  - busy=0 in cycle DIGITS+2, when a new start can be accepted.
  - Throughput: one conversion per DIGITS+2 cycles.
- start while busy=1: ignored, no queueing.
- start held high continuously: back-to-back conversions at DIGITS+2 cycle period.
- Simultaneous error and overflow: both flags set; value=0.
- DIGITS=1: a single CONV cycle; done in cycle 2.

Test Plan:
- Reset asserted 3 cycles with start=1 -> busy=done=value=err_digit=overflow=0 throughout; first start accepted in the first cycle after reset releases.
- Defaults (BASE=10, DIGITS=3, W_OUT=9); digits d2=3,d1=7,d0=5 (packed 12'h375); start pulse in cycle 0 -> busy cycles 1-4, done only in cycle 4, value=375, err_digit=0, overflow=0; busy=0 in cycle 5.
- Overflow boundary: 5,1,1 -> value=511, overflow=0. Then 5,1,2 -> overflow=1, value=0 (512 mod 512). Then 9,9,9 -> overflow=1, value=487.
- Invalid digit: d2=1, d1=4'hA, d0=2 -> err_digit=1, value=0, overflow=0. Next valid start clears err_digit on acceptance.
- Handshake and reset cases:
  - start pulses in cycles 2 and 4 during a conversion are ignored: exactly one done.
  - digits changed in cycle 1 do not affect the result.
  - reset in cycle 2 of a conversion -> busy=0 in cycle 3, no done ever, value=0.
- start held high for 15 cycles with digits=12'h042 -> done in cycles 4, 9, 14, each value=42; busy low in cycles 5 and 10; BASE=16, W_DIG=4, W_OUT=12 instance with 12'hABC -> value=2748, err_digit=0.
